// File: rtl/srff_nand.sv
// Gated set/reset flip-flop bank: each bit behaves like a four-NAND gated SR latch,
// registered on clk, with a per-bit flag for the forbidden s=r=1 state.
module srff_nand_bit #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic c,
  input  logic s,
  input  logic r,
  output logic q,
  output logic nq,
  output logic illegal
);

  // With the gate open and any request active, the NAND pair's outputs follow
  // (s, r) directly; s=r=1 drives both high. s=r=0 holds, so the forbidden
  // state persists until a valid set/reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= RST_BIT;
      nq      <= ~RST_BIT;
      illegal <= 1'b0;
    end else if (c && (s || r)) begin
      q       <= s;
      nq      <= r;
      illegal <= s & r;
    end
  end

endmodule

module srff_nand #(
  parameter int               WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_Q = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq,
  output logic [WIDTH-1:0] illegal
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    srff_nand_bit #(.RST_BIT(RST_Q[g])) u_bit (
      .clk     (clk),
      .rst     (rst),
      .c       (c),
      .s       (s[g]),
      .r       (r[g]),
      .q       (q[g]),
      .nq      (nq[g]),
      .illegal (illegal[g])
    );
  end

endmodule

// File: tb/tb_srff_nand.sv
// Scoreboard bench for srff_nand: a 1-bit (RST_Q=0) and a 4-bit (RST_Q=1010) bank
// driven together; a per-bit rule model predicts each edge's outputs.
module tb_srff_nand;

  typedef struct packed {
    logic [3:0] q4, nq4, ill4;
    logic       q1, nq1, ill1;
  } exp_t;

  localparam logic [3:0] RST4 = 4'b1010;

  logic       clk = 1'b0;
  logic       rst, c;
  logic [3:0] s, r;
  logic [3:0] q4, nq4, ill4;
  logic       q1, nq1, ill1;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference state: one entry per bit, index 4 is the 1-bit bank.
  logic m_q[5], m_nq[5], m_ill[5];

  always #5 clk = ~clk;

  srff_nand #(.WIDTH(1), .RST_Q(1'b0)) dut1 (
    .clk(clk), .rst(rst), .c(c), .s(s[0]), .r(r[0]),
    .q(q1), .nq(nq1), .illegal(ill1)
  );

  srff_nand #(.WIDTH(4), .RST_Q(RST4)) dut4 (
    .clk(clk), .rst(rst), .c(c), .s(s), .r(r),
    .q(q4), .nq(nq4), .illegal(ill4)
  );

  task automatic model_bit(input int i, input logic rv, input logic sb, input logic rb,
                           input logic rstv, input logic cv);
    if (rstv) begin
      m_q[i] = rv; m_nq[i] = !rv; m_ill[i] = 1'b0;
    end else if (cv) begin
      if (sb && rb)  begin m_q[i] = 1'b1; m_nq[i] = 1'b1; m_ill[i] = 1'b1; end
      else if (sb)   begin m_q[i] = 1'b1; m_nq[i] = 1'b0; m_ill[i] = 1'b0; end
      else if (rb)   begin m_q[i] = 1'b0; m_nq[i] = 1'b1; m_ill[i] = 1'b0; end
    end
  endtask

  // Drive one cycle's inputs at the falling edge, optionally glitch them
  // mid-cycle, and push the prediction for the coming rising edge.
  task automatic apply(input logic rstv, input logic cv, input logic [3:0] sv,
                       input logic [3:0] rv, input bit glitch);
    exp_t e;
    @(negedge clk);
    rst = rstv; c = cv; s = sv; r = rv;
    for (int i = 0; i < 4; i++) model_bit(i, RST4[i], sv[i], rv[i], rstv, cv);
    model_bit(4, 1'b0, sv[0], rv[0], rstv, cv);
    for (int i = 0; i < 4; i++) begin
      e.q4[i] = m_q[i]; e.nq4[i] = m_nq[i]; e.ill4[i] = m_ill[i];
    end
    e.q1 = m_q[4]; e.nq1 = m_nq[4]; e.ill1 = m_ill[4];
    exp_q.push_back(e);
    if (glitch) begin
      #1 c = ~cv; s = ~sv; r = ~rv;
      #1 c = cv;  s = sv;  r = rv;
    end
  endtask

  // Monitor: outputs update every edge, so every edge is a presentation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({q1, nq1, ill1} !== {e.q1, e.nq1, e.ill1}) begin
          failures++;
          $display("FAIL bank1 t=%0t got q/nq/ill=%b%b%b want %b%b%b",
                   $time, q1, nq1, ill1, e.q1, e.nq1, e.ill1);
        end
        checks++;
        if ({q4, nq4, ill4} !== {e.q4, e.nq4, e.ill4}) begin
          failures++;
          $display("FAIL bank4 t=%0t got q=%b nq=%b ill=%b want q=%b nq=%b ill=%b",
                   $time, q4, nq4, ill4, e.q4, e.nq4, e.ill4);
        end
      end
    end
  end

  initial begin
    int wait_cyc;
    rst = 1'b1; c = 1'b1; s = 4'hF; r = 4'h0;
    // reset ignores an active set
    apply(1, 1, 4'hF, 4'h0, 0);
    apply(1, 1, 4'hF, 4'h0, 0);
    // gate closed: sweep (s,r)
    apply(0, 0, 4'h0, 4'h0, 0);
    apply(0, 0, 4'h0, 4'hF, 0);
    apply(0, 0, 4'hF, 4'h0, 0);
    apply(0, 0, 4'hF, 4'hF, 0);
    // gate open: hold, set, reset, hold
    apply(0, 1, 4'h0, 4'h0, 0);
    apply(0, 1, 4'hF, 4'h0, 0);
    apply(0, 1, 4'h0, 4'hF, 0);
    apply(0, 1, 4'h0, 4'h0, 0);
    // forbidden, hold through closed gate and s=r=0, then recover
    apply(0, 1, 4'hF, 4'hF, 0);
    apply(0, 0, 4'h0, 4'hF, 0);
    apply(0, 0, 4'hF, 4'h0, 0);
    apply(0, 1, 4'h0, 4'h0, 0);
    apply(0, 1, 4'h0, 4'hF, 0);
    // reset while forbidden
    apply(0, 1, 4'hF, 4'hF, 0);
    apply(1, 0, 4'h0, 4'h0, 0);
    // multi-bit mix from reset value 1010
    apply(1, 0, 4'h0, 4'h0, 0);
    apply(0, 1, 4'b0101, 4'b1001, 0);
    // randomized traffic with between-edge glitches
    for (int n = 0; n < 400; n++)
      apply($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
            4'($urandom), 4'($urandom), $urandom_range(0, 3) == 0);
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
